port_fifo_responder: RTL and testbench
======================================

Name: port_fifo_responder

Overview:
- Port-bus responder: the device side of the CPU's portaddr/portval/portget/portset/portout interface.
- Maps a transmit FIFO, a receive FIFO and a status/count register set onto three consecutive port addresses.
- The CPU OUTs words into the TX FIFO, which an external consumer drains through a valid/ready handshake.
- An external producer fills the RX FIFO through valid/ready, and the CPU INs those words.

Parameters:
- WORD_SIZE, 16, width of port address and data words.
- BASE_ADDR, 16'h0010, port address of the DATA register; STATUS = BASE_ADDR+1, COUNT = BASE_ADDR+2.
- DEPTH_LOG2, 3, log2 of each FIFO depth (default depth 8).

Ports:
- clk  input  1  system clock, all state on rising edge.
- reset  input  1  asynchronous, active-high reset.
- portaddr  input  WORD_SIZE  port address from the CPU.
- portval  input  WORD_SIZE  write data from the CPU.
- portget  input  1  read strobe, one cycle per IN.
- portset  input  1  write strobe, one cycle per OUT.
- portout  output  WORD_SIZE  registered read data to the CPU.
- tx_data  output  WORD_SIZE  head of the TX FIFO.
- tx_valid  output  1  TX FIFO non-empty.
- tx_ready  input  1  consumer accepts tx_data this cycle.
- rx_data  input  WORD_SIZE  word from the producer.
- rx_valid  input  1  rx_data valid.
- rx_ready  output  1  RX FIFO not full.

Behaviour:
- Reset (async, immediate):
  - Both FIFO read/write pointers and counts are 0.
  - portout = 0, all sticky flags = 0.
  - Therefore tx_valid = 0 and rx_ready = 1.
  - Reset mid-transfer discards all FIFO contents.
- Address decode is an exact match on the three addresses. Other addresses:
  - Reads leave portout unchanged.
  - Writes are ignored.
  - Neither affects any state.
- Read data is registered: on a clock edge with portget=1 and a matched address, portout loads the value. portout then holds until the next matched read (the CPU samples it in a later state).
- DATA read:
  - If RX is non-empty: portout = RX head, the RX read pointer advances, count decrements.
  - If RX is empty: portout = 0, no pointer change, rx_underflow sticky is set.
- DATA write:
  - If TX is not full: portval is written at the TX write pointer, which advances, count increments.
  - If TX is full: the word is dropped and tx_overflow sticky is set.
  - Full is evaluated on the pre-edge count, so a write while full is dropped even if the consumer pops in the same cycle.
- STATUS read layout:
  - bit0 tx_full, bit1 tx_empty, bit2 rx_full, bit3 rx_empty.
  - bit4 tx_overflow, bit5 rx_underflow.
  - All other bits are 0.
- STATUS write is write-1-to-clear for bits 4 and 5; other bits are ignored.
  - If a clear and a set of the same sticky flag occur in one cycle, set wins.
- COUNT read: bits [7:0] = TX count, bits [15:8] = RX count. Counts range 0..2^DEPTH_LOG2. COUNT writes are ignored.
- TX external side:
  - tx_valid = (tx_count != 0); tx_data = mem[tx_rptr]. Both are combinational from registers.
  - A pop happens on an edge where tx_valid & tx_ready.
- RX external side:
  - rx_ready = (rx_count != DEPTH).
  - A push happens on an edge where rx_valid & rx_ready.
- Simultaneous push and pop on one FIFO: both take effect, count is unchanged, and both pointers advance.
  - TX: CPU write plus consumer pop, when not full.
  - RX: producer push plus CPU read, when not empty.
  - Empty RX with a simultaneous push and CPU read: the read sees empty (returns 0, sets underflow) and the push is stored.
- Pointers are DEPTH_LOG2 bits wide and wrap modulo DEPTH. Counts are DEPTH_LOG2+1 bits wide.
- portget and portset in the same cycle are each processed independently per their addresses.
- Latency:
  - CPU write becomes visible on tx_valid one cycle after the edge.
  - Producer push becomes readable by the next DATA read after the edge.

Test Plan:
- Reset then idle: assert reset asynchronously mid-cycle -> portout=0, tx_valid=0, rx_ready=1 immediately. A STATUS read returns 16'h000A.
- TX path: OUT 16'h1234 then 16'h5678 to 16'h0010 with tx_ready=0 -> COUNT reads 16'h0002 and tx_data=16'h1234. Raise tx_ready for 2 cycles -> 16'h1234 then 16'h5678 are popped and tx_valid=0.
- TX overflow: 9 OUTs with tx_ready=0 -> 9th word dropped, STATUS=16'h0019. OUT 16'h0010 to STATUS -> STATUS=16'h0009 (overflow cleared, still full).
- RX path and wrap: producer pushes 8 words (16'hA000..16'hA007) -> rx_ready=0. CPU reads 3, producer pushes 3 more, CPU reads 8 -> data returned in order A000..A007, A008..A00A, through the pointer wrap.
- Underflow: IN from DATA with RX empty -> portout=0, STATUS bit5=1. IN from 16'h0020 -> portout unchanged.
- Simultaneous push/pop: TX count=4, CPU OUT and tx_ready in the same cycle -> count stays 4 and order is preserved. Same check with the RX FIFO at count 1.

Source files
------------

// File: rtl/port_fifo_responder.sv
// Port-bus responder exposing a TX FIFO, an RX FIFO and status/count registers
// at three consecutive port addresses, with valid/ready on the external side.
module port_fifo_responder #(
   parameter int unsigned              WORD_SIZE  = 16,
   parameter logic [WORD_SIZE-1:0]     BASE_ADDR  = 16'h0010,
   parameter int unsigned              DEPTH_LOG2 = 3
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic [WORD_SIZE-1:0] portaddr,
   input  logic [WORD_SIZE-1:0] portval,
   input  logic                 portget,
   input  logic                 portset,
   output logic [WORD_SIZE-1:0] portout,
   output logic [WORD_SIZE-1:0] tx_data,
   output logic                 tx_valid,
   input  logic                 tx_ready,
   input  logic [WORD_SIZE-1:0] rx_data,
   input  logic                 rx_valid,
   output logic                 rx_ready
);

   localparam int unsigned DEPTH = 1 << DEPTH_LOG2;
   localparam logic [WORD_SIZE-1:0]  STAT_ADDR = BASE_ADDR + WORD_SIZE'(1);
   localparam logic [WORD_SIZE-1:0]  CNT_ADDR  = BASE_ADDR + WORD_SIZE'(2);
   localparam logic [DEPTH_LOG2:0]   FULL_CNT  = {1'b1, {DEPTH_LOG2{1'b0}}};
   localparam logic [DEPTH_LOG2:0]   CNT_ONE   = {{DEPTH_LOG2{1'b0}}, 1'b1};
   localparam logic [DEPTH_LOG2-1:0] PTR_ONE   = {{(DEPTH_LOG2-1){1'b0}}, 1'b1};

   logic [WORD_SIZE-1:0]  tx_mem [DEPTH];
   logic [WORD_SIZE-1:0]  rx_mem [DEPTH];
   logic [DEPTH_LOG2-1:0] tx_wptr_q, tx_rptr_q, rx_wptr_q, rx_rptr_q;
   logic [DEPTH_LOG2:0]   tx_count_q, tx_count_d, rx_count_q, rx_count_d;
   logic                  tx_ovf_q, tx_ovf_d, rx_unf_q, rx_unf_d;
   logic [WORD_SIZE-1:0]  portout_q, rd_word, status_word, count_word;

   logic sel_data, sel_stat, sel_cnt, rd_hit;
   logic tx_full, tx_empty, rx_full, rx_empty;
   logic tx_push, tx_pop, rx_push, rx_pop;

   assign sel_data = (portaddr == BASE_ADDR);
   assign sel_stat = (portaddr == STAT_ADDR);
   assign sel_cnt  = (portaddr == CNT_ADDR);
   assign rd_hit   = portget & (sel_data | sel_stat | sel_cnt);

   assign tx_full  = (tx_count_q == FULL_CNT);
   assign tx_empty = (tx_count_q == '0);
   assign rx_full  = (rx_count_q == FULL_CNT);
   assign rx_empty = (rx_count_q == '0);

   // Full/empty are taken from pre-edge counts, so a same-cycle pop never rescues a push.
   assign tx_push = portset & sel_data & ~tx_full;
   assign tx_pop  = tx_valid & tx_ready;
   assign rx_push = rx_valid & rx_ready;
   assign rx_pop  = portget & sel_data & ~rx_empty;

   assign tx_valid = ~tx_empty;
   assign tx_data  = tx_mem[tx_rptr_q];
   assign rx_ready = ~rx_full;
   assign portout  = portout_q;

   always_comb begin
      tx_count_d = tx_count_q;
      if (tx_push && !tx_pop) tx_count_d = tx_count_q + CNT_ONE;
      if (!tx_push && tx_pop) tx_count_d = tx_count_q - CNT_ONE;
      rx_count_d = rx_count_q;
      if (rx_push && !rx_pop) rx_count_d = rx_count_q + CNT_ONE;
      if (!rx_push && rx_pop) rx_count_d = rx_count_q - CNT_ONE;
   end

   // Set beats a same-cycle write-1-to-clear.
   always_comb begin
      tx_ovf_d = tx_ovf_q;
      rx_unf_d = rx_unf_q;
      if (portset && sel_stat && portval[4]) tx_ovf_d = 1'b0;
      if (portset && sel_stat && portval[5]) rx_unf_d = 1'b0;
      if (portset && sel_data && tx_full)    tx_ovf_d = 1'b1;
      if (portget && sel_data && rx_empty)   rx_unf_d = 1'b1;
   end

   always_comb begin
      status_word    = '0;
      status_word[0] = tx_full;
      status_word[1] = tx_empty;
      status_word[2] = rx_full;
      status_word[3] = rx_empty;
      status_word[4] = tx_ovf_q;
      status_word[5] = rx_unf_q;
      count_word     = '0;
      count_word[DEPTH_LOG2:0]       = tx_count_q;
      count_word[8 +: DEPTH_LOG2+1]  = rx_count_q;
      rd_word = '0;
      if (sel_data && !rx_empty) rd_word = rx_mem[rx_rptr_q];
      if (sel_stat)              rd_word = status_word;
      if (sel_cnt)               rd_word = count_word;
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         tx_wptr_q  <= '0;
         tx_rptr_q  <= '0;
         rx_wptr_q  <= '0;
         rx_rptr_q  <= '0;
         tx_count_q <= '0;
         rx_count_q <= '0;
         tx_ovf_q   <= 1'b0;
         rx_unf_q   <= 1'b0;
         portout_q  <= '0;
      end else begin
         if (tx_push) tx_wptr_q <= tx_wptr_q + PTR_ONE;
         if (tx_pop)  tx_rptr_q <= tx_rptr_q + PTR_ONE;
         if (rx_push) rx_wptr_q <= rx_wptr_q + PTR_ONE;
         if (rx_pop)  rx_rptr_q <= rx_rptr_q + PTR_ONE;
         tx_count_q <= tx_count_d;
         rx_count_q <= rx_count_d;
         tx_ovf_q   <= tx_ovf_d;
         rx_unf_q   <= rx_unf_d;
         if (rd_hit) portout_q <= rd_word;
      end
   end

   always_ff @(posedge clk) begin
      if (tx_push) tx_mem[tx_wptr_q] <= portval;
      if (rx_push) rx_mem[rx_wptr_q] <= rx_data;
   end

endmodule

// File: tb/tb_port_fifo_responder.sv
// Directed bench for port_fifo_responder: drives on the falling edge and samples
// on the following falling edge, with hand-computed expected values.
module tb_port_fifo_responder;

   logic        clk = 1'b0;
   logic        reset;
   logic [15:0] portaddr, portval, portout, tx_data, rx_data;
   logic        portget, portset, tx_valid, tx_ready, rx_valid, rx_ready;
   int          n_cmp = 0;
   int          n_err = 0;

   port_fifo_responder dut (
      .clk      (clk),
      .reset    (reset),
      .portaddr (portaddr),
      .portval  (portval),
      .portget  (portget),
      .portset  (portset),
      .portout  (portout),
      .tx_data  (tx_data),
      .tx_valid (tx_valid),
      .tx_ready (tx_ready),
      .rx_data  (rx_data),
      .rx_valid (rx_valid),
      .rx_ready (rx_ready)
   );

   always #5 clk = ~clk;

   task automatic do_out(input logic [15:0] addr, input logic [15:0] val);
      @(negedge clk);
      portaddr = addr;
      portval  = val;
      portset  = 1'b1;
      @(negedge clk);
      portset  = 1'b0;
   endtask

   task automatic do_in(input logic [15:0] addr);
      @(negedge clk);
      portaddr = addr;
      portget  = 1'b1;
      @(negedge clk);
      portget  = 1'b0;
   endtask

   task automatic test_reset();
      do_out(16'h0010, 16'h1111);
      do_in(16'h0011);
      n_cmp++;
      if (portout !== 16'h0008) begin
         n_err++; $display("FAIL pre_reset_status: got %h want %h", portout, 16'h0008);
      end
      #2 reset = 1'b1;
      #1;
      n_cmp++;
      if (portout !== 16'h0000 || tx_valid !== 1'b0 || rx_ready !== 1'b1) begin
         n_err++;
         $display("FAIL async_reset: portout=%h tx_valid=%b rx_ready=%b want 0000/0/1",
                  portout, tx_valid, rx_ready);
      end
      @(negedge clk);
      reset = 1'b0;
      do_in(16'h0011);
      n_cmp++;
      if (portout !== 16'h000A) begin
         n_err++; $display("FAIL reset_status: got %h want %h", portout, 16'h000A);
      end
      do_in(16'h0012);
      n_cmp++;
      if (portout !== 16'h0000) begin
         n_err++; $display("FAIL reset_count: got %h want %h", portout, 16'h0000);
      end
   endtask

   task automatic test_tx_path();
      do_out(16'h0010, 16'h1234);
      do_out(16'h0010, 16'h5678);
      do_in(16'h0012);
      n_cmp++;
      if (portout !== 16'h0002) begin
         n_err++; $display("FAIL tx_count: got %h want %h", portout, 16'h0002);
      end
      n_cmp++;
      if (tx_data !== 16'h1234 || tx_valid !== 1'b1) begin
         n_err++; $display("FAIL tx_head: got %h/%b want 1234/1", tx_data, tx_valid);
      end
      tx_ready = 1'b1;
      @(negedge clk);
      n_cmp++;
      if (tx_data !== 16'h5678 || tx_valid !== 1'b1) begin
         n_err++; $display("FAIL tx_pop1: got %h/%b want 5678/1", tx_data, tx_valid);
      end
      @(negedge clk);
      tx_ready = 1'b0;
      n_cmp++;
      if (tx_valid !== 1'b0) begin
         n_err++; $display("FAIL tx_drained: tx_valid got %b want 0", tx_valid);
      end
   endtask

   task automatic test_tx_overflow();
      for (int i = 0; i < 9; i++) do_out(16'h0010, 16'hB000 + 16'(i));
      do_in(16'h0011);
      n_cmp++;
      if (portout !== 16'h0019) begin
         n_err++; $display("FAIL tx_ovf_status: got %h want %h", portout, 16'h0019);
      end
      do_out(16'h0011, 16'h0010);
      do_in(16'h0011);
      n_cmp++;
      if (portout !== 16'h0009) begin
         n_err++; $display("FAIL tx_ovf_clear: got %h want %h", portout, 16'h0009);
      end
      // Write while full with a simultaneous pop: word must still be dropped.
      @(negedge clk);
      portaddr = 16'h0010;
      portval  = 16'hBEEF;
      portset  = 1'b1;
      tx_ready = 1'b1;
      @(negedge clk);
      portset  = 1'b0;
      tx_ready = 1'b0;
      do_in(16'h0012);
      n_cmp++;
      if (portout !== 16'h0007) begin
         n_err++; $display("FAIL full_pop_count: got %h want %h", portout, 16'h0007);
      end
      do_in(16'h0011);
      n_cmp++;
      if (portout !== 16'h0018) begin
         n_err++; $display("FAIL full_pop_status: got %h want %h", portout, 16'h0018);
      end
      @(negedge clk);
      tx_ready = 1'b1;
      for (int i = 1; i < 8; i++) begin
         n_cmp++;
         if (tx_data !== 16'hB000 + 16'(i) || tx_valid !== 1'b1) begin
            n_err++;
            $display("FAIL tx_drain_%0d: got %h/%b want %h/1", i, tx_data, tx_valid,
                     16'hB000 + 16'(i));
         end
         @(negedge clk);
      end
      tx_ready = 1'b0;
      n_cmp++;
      if (tx_valid !== 1'b0) begin
         n_err++; $display("FAIL tx_ovf_drained: tx_valid got %b want 0", tx_valid);
      end
      do_out(16'h0011, 16'h0030);
   endtask

   task automatic test_rx_wrap();
      for (int i = 0; i < 8; i++) begin
         @(negedge clk);
         rx_data  = 16'hA000 + 16'(i);
         rx_valid = 1'b1;
      end
      @(negedge clk);
      rx_valid = 1'b0;
      n_cmp++;
      if (rx_ready !== 1'b0) begin
         n_err++; $display("FAIL rx_full_ready: got %b want 0", rx_ready);
      end
      do_in(16'h0011);
      n_cmp++;
      if (portout !== 16'h0006) begin
         n_err++; $display("FAIL rx_full_status: got %h want %h", portout, 16'h0006);
      end
      for (int i = 0; i < 3; i++) begin
         do_in(16'h0010);
         n_cmp++;
         if (portout !== 16'hA000 + 16'(i)) begin
            n_err++;
            $display("FAIL rx_read_%0d: got %h want %h", i, portout, 16'hA000 + 16'(i));
         end
      end
      for (int i = 8; i < 11; i++) begin
         @(negedge clk);
         rx_data  = 16'hA000 + 16'(i);
         rx_valid = 1'b1;
      end
      @(negedge clk);
      rx_valid = 1'b0;
      for (int i = 3; i < 11; i++) begin
         do_in(16'h0010);
         n_cmp++;
         if (portout !== 16'hA000 + 16'(i)) begin
            n_err++;
            $display("FAIL rx_wrap_%0d: got %h want %h", i, portout, 16'hA000 + 16'(i));
         end
      end
   endtask

   task automatic test_underflow();
      do_in(16'h0010);
      n_cmp++;
      if (portout !== 16'h0000) begin
         n_err++; $display("FAIL rx_unf_data: got %h want %h", portout, 16'h0000);
      end
      do_in(16'h0011);
      n_cmp++;
      if (portout !== 16'h002A) begin
         n_err++; $display("FAIL rx_unf_status: got %h want %h", portout, 16'h002A);
      end
      do_in(16'h0020);
      n_cmp++;
      if (portout !== 16'h002A) begin
         n_err++; $display("FAIL unmapped_read: got %h want %h", portout, 16'h002A);
      end
      do_out(16'h0020, 16'hFFFF);
      do_out(16'h0012, 16'hFFFF);
      do_out(16'h0011, 16'h0020);
      do_in(16'h0011);
      n_cmp++;
      if (portout !== 16'h000A) begin
         n_err++; $display("FAIL unf_clear: got %h want %h", portout, 16'h000A);
      end
      do_in(16'h0012);
      n_cmp++;
      if (portout !== 16'h0000) begin
         n_err++; $display("FAIL ignored_writes: got %h want %h", portout, 16'h0000);
      end
   endtask

   task automatic test_back_to_back();
      for (int i = 0; i < 4; i++) do_out(16'h0010, 16'hC000 + 16'(i));
      @(negedge clk);
      portaddr = 16'h0010;
      portval  = 16'hC004;
      portset  = 1'b1;
      tx_ready = 1'b1;
      @(negedge clk);
      portset  = 1'b0;
      tx_ready = 1'b0;
      do_in(16'h0012);
      n_cmp++;
      if (portout !== 16'h0004) begin
         n_err++; $display("FAIL tx_simul_count: got %h want %h", portout, 16'h0004);
      end
      @(negedge clk);
      tx_ready = 1'b1;
      for (int i = 1; i < 5; i++) begin
         n_cmp++;
         if (tx_data !== 16'hC000 + 16'(i)) begin
            n_err++;
            $display("FAIL tx_simul_%0d: got %h want %h", i, tx_data, 16'hC000 + 16'(i));
         end
         @(negedge clk);
      end
      tx_ready = 1'b0;
      @(negedge clk);
      rx_data  = 16'hD000;
      rx_valid = 1'b1;
      @(negedge clk);
      rx_data  = 16'hD001;
      portaddr = 16'h0010;
      portget  = 1'b1;
      @(negedge clk);
      rx_valid = 1'b0;
      portget  = 1'b0;
      n_cmp++;
      if (portout !== 16'hD000) begin
         n_err++; $display("FAIL rx_simul_data: got %h want %h", portout, 16'hD000);
      end
      do_in(16'h0012);
      n_cmp++;
      if (portout !== 16'h0100) begin
         n_err++; $display("FAIL rx_simul_count: got %h want %h", portout, 16'h0100);
      end
      do_in(16'h0010);
      n_cmp++;
      if (portout !== 16'hD001) begin
         n_err++; $display("FAIL rx_simul_next: got %h want %h", portout, 16'hD001);
      end
      // Empty RX: read sees empty while the same-cycle push is kept.
      @(negedge clk);
      rx_data  = 16'hE000;
      rx_valid = 1'b1;
      portaddr = 16'h0010;
      portget  = 1'b1;
      @(negedge clk);
      rx_valid = 1'b0;
      portget  = 1'b0;
      n_cmp++;
      if (portout !== 16'h0000) begin
         n_err++; $display("FAIL rx_empty_simul: got %h want %h", portout, 16'h0000);
      end
      do_in(16'h0011);
      n_cmp++;
      if (portout !== 16'h0022) begin
         n_err++; $display("FAIL rx_empty_simul_status: got %h want %h", portout, 16'h0022);
      end
      do_in(16'h0010);
      n_cmp++;
      if (portout !== 16'hE000) begin
         n_err++; $display("FAIL rx_empty_simul_kept: got %h want %h", portout, 16'hE000);
      end
   endtask

   initial begin
      reset    = 1'b1;
      portaddr = '0;
      portval  = '0;
      portget  = 1'b0;
      portset  = 1'b0;
      tx_ready = 1'b0;
      rx_data  = '0;
      rx_valid = 1'b0;
      repeat (2) @(negedge clk);
      reset = 1'b0;
      test_reset();
      test_tx_path();
      test_tx_overflow();
      test_rx_wrap();
      test_underflow();
      test_back_to_back();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
